// File: rtl/maze_player_ctrl_if.sv
// maze_player_ctrl_if: wall-lookup query handshake between the player controller and the maze wall map
interface maze_player_ctrl_if;
    logic       req;
    logic [4:0] x;
    logic [4:0] y;
    logic       ack;
    logic       hit;

    modport master (output req, x, y, input ack, hit);
    modport slave  (input req, x, y, output ack, hit);
endinterface

// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: frame-paced player stepping with a wall-lookup handshake, win and timeout flags
module maze_player_ctrl #(
    parameter int GRID_W          = 32,
    parameter int GRID_H          = 24,
    parameter int START_X         = 1,
    parameter int START_Y         = 1,
    parameter int GOAL_X          = 30,
    parameter int GOAL_Y          = 22,
    parameter int FRAMES_PER_STEP = 8,
    parameter int ACK_TIMEOUT     = 255
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iVSYNC,
    input  logic               iEnable,
    input  logic [3:0]         iDir,
    maze_player_ctrl_if.master wall,
    output logic [4:0]         oPos_X,
    output logic [4:0]         oPos_Y,
    output logic               oMoved,
    output logic               oWin,
    output logic               oErr
);
    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {WAIT_FRAME, SAMPLE, QUERY, UPDATE, WON} state_t;

    state_t        state_q, state_d;
    logic          vs_q, vs_d, tick_q, tick_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [4:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [4:0]    wx_q, wx_d, wy_q, wy_d;
    logic          req_q, req_d, moved_q, moved_d, win_q, win_d, err_q, err_d;
    logic          step, up, dn, lf, rt, ok, timeout, at_goal;
    logic [4:0]    tgt_x, tgt_y;

    // VSYNC falling-edge tick, frame pacing and query timeout counter
    always_comb begin
        vs_d    = iVSYNC;
        tick_d  = vs_q & ~iVSYNC;
        step    = tick_q && cnt_q == CW'(FRAMES_PER_STEP - 1);
        cnt_d   = tick_q ? (step ? '0 : cnt_q + CW'(1)) : cnt_q;
        tmo_d   = (state_q == QUERY) ? tmo_q + TW'(1) : '0;
        timeout = tmo_q == TW'(ACK_TIMEOUT - 1);
    end

    // direction priority up>down>left>right and in-grid target cell
    always_comb begin
        up      = iDir[3];
        dn      = ~iDir[3] & iDir[2];
        lf      = ~|iDir[3:2] & iDir[1];
        rt      = ~|iDir[3:1] & iDir[0];
        ok      = up ? pos_y_q != 5'd0 :
                  dn ? pos_y_q != 5'(GRID_H - 1) :
                  lf ? pos_x_q != 5'd0 :
                  rt ? pos_x_q != 5'(GRID_W - 1) : 1'b0;
        tgt_x   = lf ? pos_x_q - 5'd1 : rt ? pos_x_q + 5'd1 : pos_x_q;
        tgt_y   = up ? pos_y_q - 5'd1 : dn ? pos_y_q + 5'd1 : pos_y_q;
        at_goal = pos_x_q == 5'(GOAL_X) && pos_y_q == 5'(GOAL_Y);
    end

    // step FSM: sample direction, query wall map, commit move or give up
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        req_d   = req_q;
        moved_d = 1'b0;
        win_d   = win_q;
        err_d   = err_q;
        case (state_q)
            WAIT_FRAME: state_d = (step && iEnable && !win_q) ? SAMPLE : WAIT_FRAME;
            SAMPLE: begin
                state_d = ok ? QUERY : WAIT_FRAME;
                req_d   = ok;
                wx_d    = ok ? tgt_x : wx_q;
                wy_d    = ok ? tgt_y : wy_q;
            end
            QUERY: begin
                if (wall.ack) begin
                    req_d   = 1'b0;
                    state_d = wall.hit ? WAIT_FRAME : UPDATE;
                    pos_x_d = wall.hit ? pos_x_q : wx_q;
                    pos_y_d = wall.hit ? pos_y_q : wy_q;
                    moved_d = ~wall.hit;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = WAIT_FRAME;
                end
            end
            UPDATE: begin
                win_d   = at_goal;
                state_d = at_goal ? WON : WAIT_FRAME;
            end
            WON:     state_d = WON;
            default: state_d = WAIT_FRAME;
        endcase
    end

    // state registers; reset abandons any in-flight query
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= WAIT_FRAME;
            vs_q    <= 1'b0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            pos_x_q <= 5'(START_X);
            pos_y_q <= 5'(START_Y);
            wx_q    <= '0;
            wy_q    <= '0;
            req_q   <= 1'b0;
            moved_q <= 1'b0;
            win_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            req_q   <= req_d;
            moved_q <= moved_d;
            win_q   <= win_d;
            err_q   <= err_d;
        end
    end

    assign wall.req = req_q;
    assign wall.x   = wx_q;
    assign wall.y   = wy_q;
    assign oPos_X   = pos_x_q;
    assign oPos_Y   = pos_y_q;
    assign oMoved   = moved_q;
    assign oWin     = win_q;
    assign oErr     = err_q;
endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: directed table, random steps against a grid-rule model, timeout/reset/goal sequences
module tb_maze_player_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, vsync = 1'b1, en = 1'b0;
    logic [3:0] dir = 4'd0;
    logic [4:0] px, py;
    logic       moved, win, err;

    maze_player_ctrl_if wall();

    maze_player_ctrl dut (
        .iCLK(clk), .iRST_N(rst_n), .iVSYNC(vsync), .iEnable(en), .iDir(dir),
        .wall(wall), .oPos_X(px), .oPos_Y(py), .oMoved(moved), .oWin(win), .oErr(err)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    int   q_cnt = 0, qx = 0, qy = 0, req_cyc = 0, mv_cnt = 0;
    logic rsp_hit = 1'b0;
    int   rsp_dly = 0;
    int   mx = 1, my = 1;
    bit   mwin = 1'b0, merr = 1'b0;

    typedef struct {
        logic [3:0] d;
        logic       e;
        logic       h;
        int         dly;
        int         ex;
        int         ey;
        int         eq;
    } vec_t;
    vec_t tbl[12];

    // wall-map responder: ack each query after rsp_dly cycles, even if the query already went away
    initial begin
        wall.ack = 1'b0;
        wall.hit = 1'b0;
        forever begin
            @(negedge clk);
            if (wall.req) begin
                q_cnt++;
                qx = wall.x;
                qy = wall.y;
                repeat (rsp_dly) @(negedge clk);
                wall.ack = 1'b1;
                wall.hit = rsp_hit;
                @(negedge clk);
                wall.ack = 1'b0;
                wall.hit = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (wall.req) req_cyc <= req_cyc + 1;
        if (moved) mv_cnt <= mv_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic frame(input int hi);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    // one FRAMES_PER_STEP window; expectation from grid rules
    task automatic step(input logic [3:0] d, input logic e, input logic h, input int dly, input int hi);
        int tx, ty, eq, em, q0, r0, m0;
        tx = mx; ty = my; eq = 0; em = 0;
        if (e && !mwin && d != 4'd0) begin
            if (d[3]) ty--; else if (d[2]) ty++; else if (d[1]) tx--; else tx++;
            if (tx >= 0 && tx < 32 && ty >= 0 && ty < 24) begin
                eq = 1;
                if (dly >= 255) merr = 1'b1;
                else if (!h) begin
                    mx = tx; my = ty; em = 1;
                    mwin = (tx == 30 && ty == 22);
                end
            end
        end
        dir = d; en = e; rsp_hit = h; rsp_dly = dly;
        q0 = q_cnt; r0 = req_cyc; m0 = mv_cnt;
        repeat (8) frame(hi);
        #1;
        chk("query_count", q_cnt - q0, eq);
        if (eq == 1) begin
            chk("query_x", qx, tx);
            chk("query_y", qy, ty);
            chk("req_cycles", req_cyc - r0, (dly >= 255) ? 255 : dly + 1);
        end
        chk("moved_pulses", mv_cnt - m0, em);
        chk("pos_x", px, mx);
        chk("pos_y", py, my);
        chk("win", win, mwin);
        chk("err", err, merr);
        chk("req_idle", wall.req, 0);
    endtask

    initial begin
        logic seen;
        int   m0;
        tbl[0]  = '{4'b0001, 1'b1, 1'b0, 2, 2, 1, 1};
        tbl[1]  = '{4'b1000, 1'b1, 1'b0, 0, 2, 0, 1};
        tbl[2]  = '{4'b1000, 1'b1, 1'b0, 0, 2, 0, 0};
        tbl[3]  = '{4'b1001, 1'b1, 1'b0, 0, 2, 0, 0};
        tbl[4]  = '{4'b0010, 1'b1, 1'b1, 5, 2, 0, 1};
        tbl[5]  = '{4'b0100, 1'b1, 1'b0, 1, 2, 1, 1};
        tbl[6]  = '{4'b0001, 1'b0, 1'b0, 0, 2, 1, 0};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 0, 2, 1, 0};
        tbl[8]  = '{4'b0010, 1'b1, 1'b0, 3, 1, 1, 1};
        tbl[9]  = '{4'b0010, 1'b1, 1'b0, 0, 0, 1, 1};
        tbl[10] = '{4'b0010, 1'b1, 1'b0, 0, 0, 1, 0};
        tbl[11] = '{4'b0110, 1'b1, 1'b0, 4, 0, 2, 1};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_pos_x", px, 1);
        chk("rst_pos_y", py, 1);
        chk("rst_req", wall.req, 0);
        chk("rst_wall_x", wall.x, 0);
        chk("rst_wall_y", wall.y, 0);
        chk("rst_moved", moved, 0);
        chk("rst_win", win, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            m0 = q_cnt;
            step(tbl[i].d, tbl[i].e, tbl[i].h, tbl[i].dly, 20);
            chk("tbl_x", px, tbl[i].ex);
            chk("tbl_y", py, tbl[i].ey);
            chk("tbl_q", q_cnt - m0, tbl[i].eq);
        end

        for (int i = 0; i < 40; i++)
            step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 10)), 20);

        step((mx < 31) ? 4'b0001 : 4'b0010, 1'b1, 1'b0, 254, 300);
        step((mx < 31) ? 4'b0001 : 4'b0010, 1'b1, 1'b0, 255, 300);
        step((mx < 31) ? 4'b0001 : 4'b0010, 1'b1, 1'b0, 3, 20);

        dir = 4'b0001; en = 1'b1; rsp_hit = 1'b0; rsp_dly = 20;
        m0 = mv_cnt;
        repeat (7) frame(20);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = wall.req;
        end
        chk("query_seen", seen, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", wall.req, 0);
        chk("async_rst_x", px, 1);
        chk("async_rst_y", py, 1);
        chk("async_rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mx = 1; my = 1; mwin = 1'b0; merr = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("late_ack_moved", mv_cnt - m0, 0);
        chk("late_ack_x", px, 1);
        chk("late_ack_y", py, 1);
        chk("late_ack_req", wall.req, 0);

        for (int i = 0; i < 21; i++) step(4'b0100, 1'b1, 1'b0, int'($urandom_range(0, 8)), 20);
        for (int i = 0; i < 29; i++) step(4'b0001, 1'b1, 1'b0, int'($urandom_range(0, 8)), 20);
        chk("goal_win", win, 1);
        step(4'b0010, 1'b1, 1'b0, 0, 20);
        step(4'b1000, 1'b1, 1'b0, 0, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
